// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide sequencer.
//   - md_op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU)
//   - default latencies for multiply and divide
//   - sequencer state encodings
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // Both divide encodings have bit 1 set.
  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/md_if.sv
// md_if: E-stage request / HI-LO result bundle for md_unit.
//   start, md_op, A, B, hi_we, lo_we : decode/forwarding side -> md_unit
//   busy, HI, LO                     : md_unit -> hazard unit / mfhi/mflo path
interface md_if;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        hi_we;
  logic        lo_we;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, md_op, A, B, hi_we, lo_we,
    input  busy, HI, LO
  );

  modport slave (
    input  start, md_op, A, B, hi_we, lo_we,
    output busy, HI, LO
  );
endinterface

// File: rtl/md_arith.sv
// md_arith: combinational multiply/divide datapath.
//   i_op   : md_op encoding
//   i_a    : rs operand (dividend / multiplicand)
//   i_b    : rt operand (divisor / multiplier)
//   o_hi   : product[63:32] or remainder
//   o_lo   : product[31:0]  or quotient
//   o_div0 : divide op with zero divisor (result must be discarded)
module md_arith
  import md_pkg::*;
(
  input  logic [1:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_div0
);

  logic        w_sgn;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_b_zero;
  logic [31:0] w_den;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_q;
  logic [31:0] w_r;

  assign w_sgn = (i_op == MD_MULT) || (i_op == MD_DIV);

  // The low 64 bits of a 64x64 product of sign-extended operands equal the
  // signed 32x32 product, so one multiplier serves both flavours.
  assign w_a_ext = {{32{w_sgn & i_a[31]}}, i_a};
  assign w_b_ext = {{32{w_sgn & i_b[31]}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Signed division on magnitudes, then restore signs. 0x80000000 has
  // magnitude 0x80000000 as unsigned, so the overflow case falls out
  // naturally (LO = 0x80000000, HI = 0).
  assign w_a_neg  = w_sgn & i_a[31];
  assign w_b_neg  = w_sgn & i_b[31];
  assign w_a_mag  = w_a_neg ? (~i_a + 32'd1) : i_a;
  assign w_b_mag  = w_b_neg ? (~i_b + 32'd1) : i_b;
  assign w_b_zero = (i_b == 32'd0);
  // Keep the divider X-free on a zero divisor; the result is discarded anyway.
  assign w_den    = w_b_zero ? 32'd1 : w_b_mag;
  assign w_uq     = w_a_mag / w_den;
  assign w_ur     = w_a_mag % w_den;
  assign w_q      = (w_a_neg ^ w_b_neg) ? (~w_uq + 32'd1) : w_uq;
  assign w_r      = w_a_neg ? (~w_ur + 32'd1) : w_ur;

  always_comb begin
    o_hi = w_prod[63:32];
    o_lo = w_prod[31:0];
    if (md_is_div(i_op)) begin
      o_hi = w_r;
      o_lo = w_q;
    end
  end

  assign o_div0 = md_is_div(i_op) & w_b_zero;

endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide sequencer owning HI/LO.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : md_if.slave (start/md_op/A/B/hi_we/lo_we in; busy/HI/LO out)
//
// state   | meaning
// MD_IDLE | busy=0; accepts start (priority) or mthi/mtlo
// MD_RUN  | busy=1; cnt counts down, result committed when cnt==1
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  bus
);

  localparam logic [3:0] LP_MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] LP_DIV_CNT  = 4'(DIV_CYCLES);

  md_state_e   r_state;
  md_state_e   w_state_nxt;
  logic [3:0]  r_cnt;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic        r_pend_div0;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_load;
  logic        w_commit;
  logic        w_mt_hi;
  logic        w_mt_lo;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_res_div0;

  md_arith u_arith (
    .i_op   (bus.md_op),
    .i_a    (bus.A),
    .i_b    (bus.B),
    .o_hi   (w_res_hi),
    .o_lo   (w_res_lo),
    .o_div0 (w_res_div0)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= MD_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    w_mt_hi     = 1'b0;
    w_mt_lo     = 1'b0;
    case (r_state)
      MD_IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = MD_RUN;
        end else begin
          w_mt_hi = bus.hi_we;
          w_mt_lo = bus.lo_we;
        end
      end
      MD_RUN: begin
        if (r_cnt == 4'd1) begin
          w_commit    = 1'b1;
          w_state_nxt = MD_IDLE;
        end
      end
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= 4'd0;
      r_pend_hi   <= 32'd0;
      r_pend_lo   <= 32'd0;
      r_pend_div0 <= 1'b0;
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
    end else begin
      if (w_load) begin
        r_cnt       <= md_is_div(bus.md_op) ? LP_DIV_CNT : LP_MULT_CNT;
        r_pend_hi   <= w_res_hi;
        r_pend_lo   <= w_res_lo;
        r_pend_div0 <= w_res_div0;
      end else if (r_state == MD_RUN) begin
        r_cnt <= r_cnt - 4'd1;
      end

      // Divide by zero runs full latency but leaves HI/LO untouched.
      if (w_commit) begin
        if (!r_pend_div0) begin
          r_hi <= r_pend_hi;
          r_lo <= r_pend_lo;
        end
      end else begin
        if (w_mt_hi) r_hi <= bus.A;
        if (w_mt_lo) r_lo <= bus.A;
      end
    end
  end

  assign bus.busy = (r_state == MD_RUN);
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide sequencer for the P6 pipelined MIPS core, sitting in the E stage beside the ALU. It accepts `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo` from the E-stage control decode. It owns the HI/LO registers and holds `busy` for a fixed latency so the hazard unit can stall `mfhi`/`mflo` and further md instructions in D.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy duration of `mult`/`multu`; legal range 1..15.
- `DIV_CYCLES`, default 10: busy duration of `div`/`divu`; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  E-stage instruction is mult/multu/div/divu; qualified by `md_op`.
- `md_op`  in  2  operation: 0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU.
- `A`  in  32  rs operand, already forwarded.
- `B`  in  32  rt operand, already forwarded.
- `hi_we`  in  1  `mthi`: write `A` to HI.
- `lo_we`  in  1  `mtlo`: write `A` to LO.
- `busy`  out  1  operation in flight.
- `HI`  out  32  HI register.
- `LO`  out  32  LO register.

## Operation
- There are two states:
  - IDLE: `busy` = 0.
  - RUN: `busy` = 1, with a 4-bit down-counter `cnt`.
- IDLE with `start` = 1:
  - Compute the result combinationally from `A`, `B`, `md_op` and latch it into `pend_hi`/`pend_lo`.
  - Load `cnt` with `MULT_CYCLES` (op 0/1) or `DIV_CYCLES` (op 2/3), then go to RUN.
- RUN:
  - Decrement `cnt` each cycle.
  - When `cnt` == 1: copy `pend_hi`/`pend_lo` into `HI`/`LO` and return to IDLE.
- IDLE with `hi_we` or `lo_we` (and `start` = 0): write `A` to HI and/or LO on the next edge.
  - If both are set, both registers get `A`.
- Priority in IDLE is `start` over `hi_we`/`lo_we`. If they arrive in the same cycle, the writes are dropped.
- In RUN, `start`, `hi_we` and `lo_we` are ignored. Upstream stalls guarantee they do not arrive then; the bench checks that they are ignored.
- Arithmetic:
  - MULT: signed 32x32 → 64; HI = [63:32], LO = [31:0].
  - MULTU: the same, unsigned.
  - DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV with A = 0x80000000, B = 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - Divide by zero (B = 0): the operation runs its full latency, then HI/LO stay unchanged.
- Reset, including mid-RUN: `busy` = 0, `HI` = 0, `LO` = 0, `cnt` = 0, `pend_*` = 0, state IDLE. Any in-flight result is discarded.

## Timing
- `start` is sampled at edge T. `busy` is 1 during cycles T+1 .. T+N (N = the latency for the op).
- New HI/LO are visible from cycle T+N+1, the same cycle `busy` falls.
- Back-to-back: a new `start` is accepted in cycle T+N+1 (IDLE again). There are no dead cycles.
- `mthi`/`mtlo` in IDLE: HI/LO are updated one edge later.
- `busy` and `HI`/`LO` are registered outputs with no combinational path from inputs.
- The D-stage hazard unit stalls on `(start | busy)` for md/mfhi/mflo instructions. `md_unit` itself never waits on anything.

## Structure
- Shared package `md_pkg` holds:
  - The `md_op` encodings: `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`.
  - Defaults `MD_MULT_CYCLES` = 5 and `MD_DIV_CYCLES` = 10.
  - The state encodings `MD_IDLE` and `MD_RUN`.
- Sub-module `md_arith`: purely combinational 64-bit product and quotient/remainder, including the signed-division sign fix-ups and the divide-by-zero flag.
- `md_unit` contains only the FSM, the counter and the registers.

## Test plan
- MULT A = 0xFFFFFFFE (−2), B = 3 → `busy` for exactly 5 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA; MULTU with the same operands → HI = 0x00000002, LO = 0xFFFFFFFA.
- DIV A = 0xFFFFFFF9 (−7), B = 2 → `busy` for 10 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIVU A = 7, B = 2 → LO = 3, HI = 1.
- `mthi` A = 0x12345678, then DIV with B = 0 → after 10 busy cycles HI = 0x12345678 and LO unchanged; DIV A = 0x80000000, B = 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- MULT started, with `start`/`mtlo` pulsed at busy cycle 3 → both ignored, and the final HI/LO equal the original MULT result; `start` + `hi_we` in the same IDLE cycle → HI is not written by `mthi`.
- `reset` asserted asynchronously at busy cycle 4 of a DIV → `busy`, HI, LO = 0 immediately; after release, a MULT completes normally.
- Back-to-back MULT then DIV, with the second `start` in the cycle `busy` falls → `busy` falls after the MULT, then goes high again for exactly 10 cycles; results are correct for both operations.
